dn_route_ctrl: RTL
==================

DN_ROUTE_CTRL -- requirements
Module: dn_route_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, meaning Benes network port count (power of two, >=4).
REQ-002 SHALL have parameter N_LEVELS, default 2*$clog2(N)-1, meaning router stages in the Benes network.
REQ-003 SHALL derive N_BEATS = N_LEVELS-1 and ROUTE_W = N_BEATS*N, meaning configuration beats per route set and route_signals width.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid  input  1  configuration beat offered.
REQ-007 SHALL have port cfg_ready  output  1  configuration beat acceptable this cycle.
REQ-008 SHALL have port cfg_data  input  N  one stage's route bits, 2 bits per router, router p at bits [2p+1:2p].
REQ-009 SHALL have port cfg_last  input  1  marks final beat of a route set.
REQ-010 SHALL have port run  input  1  upstream data-stream enable.
REQ-011 SHALL have port set_en  output  1  one-cycle pulse latching new routes into the Benes routers.
REQ-012 SHALL have port route_en  output  1  Benes routers forward data.
REQ-013 SHALL have port route_signals  output  ROUTE_W  active route set, drives the Benes network route input.
REQ-014 SHALL have port active_valid  output  1  a committed route set is held.
REQ-015 SHALL have port err  output  1  one-cycle pulse on a malformed route set.

Function
REQ-016 SHALL accept a beat when cfg_valid and cfg_ready are both high at a rising clk edge.
REQ-017 SHALL write beat k (k = 0..N_BEATS-1, counted per set) into shadow[k*N +: N]; beat counter increments per accepted beat.
REQ-018 SHALL use FSM states IDLE (counter 0), LOAD (counter 1..N_BEATS-1), COMMIT (single cycle); IDLE->LOAD on first non-final accept, LOAD->COMMIT on final accept, IDLE->COMMIT when N_BEATS=1, COMMIT->IDLE always.
REQ-019 SHALL drive cfg_ready low only in COMMIT; high in IDLE and LOAD, including while route_en is high (shadow loading overlaps routing).
REQ-020 SHALL, in COMMIT, copy shadow to route_signals, set active_valid=1, assert set_en for exactly that cycle, and clear the beat counter.
REQ-021 SHALL give latency: final beat accepted at edge t -> route_signals updated and set_en high in cycle t+1 -> route_en may rise in cycle t+2.
REQ-022 SHALL drive route_en = active_valid AND run AND NOT set_en, registered-state combinational (no extra cycle).
REQ-023 SHALL keep route_signals and active_valid unchanged outside COMMIT; a partially loaded shadow never alters route_signals.
REQ-024 SHALL treat simultaneous run rise and COMMIT as COMMIT-first: route_en low that cycle.
REQ-025 SHALL not stall or drop beats while cfg_valid is held continuously; back-to-back sets are separated by exactly one COMMIT cycle.

Reset
REQ-026 SHALL, on reset low (asynchronous, any state including mid-LOAD), clear FSM to IDLE, counter, shadow, route_signals to 0, active_valid, set_en, route_en, err to 0; cfg_ready 0 while reset low, 1 first cycle after release.
REQ-027 SHALL discard any partially loaded set on reset; no COMMIT follows release.

Configuration
REQ-028 SHALL compile framing checks only when macro DN_ROUTE_CTRL_CHECK_EN is defined.
REQ-029 SHALL, with DN_ROUTE_CTRL_CHECK_EN: on cfg_last with counter != N_BEATS-1, or counter = N_BEATS-1 without cfg_last, pulse err next cycle, discard shadow, return to IDLE, no set_en, active set unchanged.
REQ-030 SHALL, without DN_ROUTE_CTRL_CHECK_EN: ignore cfg_last, commit purely on counter = N_BEATS-1, tie err to 0.

Verification (N=8: N_LEVELS=5, N_BEATS=4, ROUTE_W=32)
REQ-031 SHALL cover: reset release, beats 0x11,0x22,0x33,0x44 (last on 4th) -> next cycle route_signals=0x44332211, set_en=1 one cycle, active_valid=1.
REQ-032 SHALL cover: run=1 held across commit -> route_en 0 in set_en cycle, 1 the following cycle.
REQ-033 SHALL cover: second set 0xAA,0xBB,0xCC,0xDD loaded while route_en=1 -> route_signals stays 0x44332211 until its COMMIT, then 0xDDCCBBAA; cfg_ready low only that cycle.
REQ-034 SHALL cover: reset asserted after 2 beats -> all outputs 0 immediately; after release 4 new beats commit normally.
REQ-035 SHALL cover (CHECK_EN): cfg_last on 2nd beat -> err pulses 1 cycle, no set_en, route_signals unchanged; next well-formed set commits.
REQ-036 SHALL cover (no CHECK_EN): same stimulus -> no err, commit after 4th beat.

Source files
------------

// File: rtl/dn_route_ctrl.sv
// Benes route-set loader: gathers N_BEATS configuration beats into a shadow and commits them atomically.
// Framing checks on cfg_last are compiled in only when DN_ROUTE_CTRL_CHECK_EN is defined.
module dn_route_ctrl #(
    parameter int N        = 32,
    parameter int N_LEVELS = 2*$clog2(N)-1,
    localparam int N_BEATS = N_LEVELS-1,
    localparam int ROUTE_W = N_BEATS*N
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [N-1:0]       cfg_data,
    input  logic               cfg_last,
    input  logic               run,
    output logic               set_en,
    output logic               route_en,
    output logic [ROUTE_W-1:0] route_signals,
    output logic               active_valid,
    output logic               err,
    output logic [1:0]         state_dbg
);
    localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ROUTE_W-1:0] shadow, shadow_nxt;
    logic               accept, last_beat, bad_frame, commit_go;

    // Handshake: a beat transfers on a rising edge where cfg_valid && cfg_ready are both high;
    // cfg_ready depends only on FSM state (low in COMMIT and in reset), never on cfg_valid.
    assign cfg_ready = reset && (state != COMMIT);
    assign accept    = cfg_valid && cfg_ready;
    assign last_beat = (cnt == CNT_W'(N_BEATS-1));

`ifdef DN_ROUTE_CTRL_CHECK_EN
    assign bad_frame = accept && (cfg_last != last_beat);
`else
    logic unused_cfg_last;
    assign unused_cfg_last = cfg_last;
    assign bad_frame = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        commit_go  = 1'b0;
        case (state)
            COMMIT: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                if (accept) begin
                    shadow_nxt[cnt*N +: N] = cfg_data;
                    if (bad_frame) begin
                        state_nxt  = IDLE;
                        cnt_nxt    = '0;
                        shadow_nxt = '0;
                    end else if (last_beat) begin
                        state_nxt = COMMIT;
                        commit_go = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                        cnt_nxt   = cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    // The active set is loaded on the edge entering COMMIT so it is already visible while set_en is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            shadow        <= '0;
            route_signals <= '0;
            active_valid  <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            if (commit_go) begin
                route_signals <= shadow_nxt;
                active_valid  <= 1'b1;
            end
        end
    end

`ifdef DN_ROUTE_CTRL_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bad_frame;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign set_en    = (state == COMMIT);
    assign route_en  = active_valid && run && !set_en;
    assign state_dbg = state;
endmodule
